// File: rtl/matrix_loader_hps_to_fpga.sv
// Inbound matrix loader: collects row-major elements from the HPS and places
// them into the zero-padded 5x5 packed operand layout used by the matrix ALU.
module matrix_loader_hps_to_fpga #(
    parameter int ELEM_W  = 8,
    parameter int DIM_MAX = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [1:0]                        size,
    input  logic                              in_valid,
    input  logic [ELEM_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ELEM_W*DIM_MAX*DIM_MAX-1:0] matrix_out,
    output logic                              busy
);

    localparam int NUM_ELEM = DIM_MAX * DIM_MAX;
    localparam int MAT_W    = ELEM_W * NUM_ELEM;
    localparam int IDX_W    = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [MAT_W-1:0]   buf_q, buf_d;

    logic               clear_buf;
    logic               accept;
    logic [2:0]         last_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [NUM_ELEM-1:0] wr_sel;

    assign last_idx = n_q - 3'd1;

    // Flat slot index in the 5x5 grid; slot 0 sits in the top byte.
    assign wr_idx = IDX_W'(row_q) * IDX_W'(DIM_MAX) + IDX_W'(col_q);

    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_wr_sel
        assign wr_sel[gi] = accept && (wr_idx == IDX_W'(gi));
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        clear_buf = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    clear_buf = 1'b1;
                    n_d       = 3'(size) + 3'd2;
                    row_d     = 3'd0;
                    col_d     = 3'd0;
                end
            end
            ST_LOAD: begin
                // A restart wins over an element offered in the same cycle.
                if (start) begin
                    clear_buf = 1'b1;
                    n_d       = 3'(size) + 3'd2;
                    row_d     = 3'd0;
                    col_d     = 3'd0;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (col_q == last_idx) begin
                        col_d = 3'd0;
                        if (row_q == last_idx) begin
                            state_d = ST_DONE;
                            row_d   = 3'd0;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        buf_d = buf_q;
        if (clear_buf) begin
            buf_d = '0;
        end else begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                if (wr_sel[i]) begin
                    buf_d[MAT_W-1-ELEM_W*i -: ELEM_W] = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= 3'd2;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign matrix_out = buf_q;

endmodule

// File: doc/matrix_loader_hps_to_fpga.md
# matrix_loader_hps_to_fpga

Receives matrix elements one at a time from the HPS side and assembles them into the coprocessor's packed 200-bit 5x5 operand layout, zero-padding the unused rows and columns. It accepts 2x2, 3x3, 4x4 and 5x5 matrices. It sits between the HPS command/data path and the matrix ALU operand registers. It is the inbound counterpart of the result path that compacts 5x5-packed results back to HPS order.

## Interface

Parameters:
- ELEM_W, 8, element width in bits. The layout below requires 8.
- DIM_MAX, 5, maximum matrix dimension. The packed width is ELEM_W*DIM_MAX*DIM_MAX = 200.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- size  in  2  matrix dimension, sampled with start: 00=2x2, 01=3x3, 10=4x4, 11=5x5
- in_valid  in  1  HPS presents an element
- in_data  in  8  element value, treated as raw bits
- in_ready  out  1  loader accepts an element this cycle
- out_valid  out  1  assembled matrix available
- out_ready  in  1  consumer takes the matrix
- matrix_out  out  200  packed 5x5 matrix
- busy  out  1  high in LOAD or DONE

## Operation

- FSM states:
  - IDLE: in_ready=0, out_valid=0.
  - LOAD: in_ready=1.
  - DONE: out_valid=1, in_ready=0.
- Transitions:
  - IDLE + start -> LOAD. The buffer is cleared to 0, n=size+2 is latched, and row/col counters are set to 0.
  - LOAD + accepted element (in_valid & in_ready) -> the element is written, then the counters advance.
  - LOAD + accepted element with row=n-1 and col=n-1 -> DONE.
  - DONE + out_ready -> IDLE.
- Element placement: element (r,c) goes to matrix_out[199-40r-8c -: 8], i.e. a 40-bit row stride and an 8-bit column stride.
  - (0,0)=[199:192], (0,1)=[191:184], (1,0)=[159:152], (4,4)=[7:0].
- Counter advance: col increments. When col=n-1, col wraps to 0 and row increments. Counters are 3 bits wide and never exceed n-1.
- All positions with r>=n or c>=n remain 0.
- Input order: the HPS sends exactly n*n elements in row-major order.
- start in LOAD restarts the load:
  - the buffer clears, the new size is latched, and the counters reset;
  - any element presented in that same cycle is discarded.
- start in DONE is ignored.
- in_valid outside LOAD is ignored and has no side effects.
- matrix_out is driven directly from the buffer register and is stable throughout DONE. Its contents outside DONE are don't-care for consumers.
- busy is asserted in LOAD and DONE.

## Timing

- Reset: state=IDLE, buffer=0, counters=0, n latch=2. Outputs: in_ready=0, out_valid=0, busy=0, matrix_out=0.
- Reset has priority over every other input. Asserting reset in LOAD or DONE aborts the load next cycle; no partial matrix is ever presented.
- start at edge t means in_ready=1 from cycle t+1.
- One element is accepted per cycle when in_valid is held high. A 3x3 load takes 9 accepting cycles.
- The last element is accepted at edge t: out_valid=1 from t+1, and that element is visible in matrix_out at t+1.
- Latency from the start edge to out_valid = n*n+1 cycles with no input stalls (minimum 5 for 2x2, 26 for 5x5).
- out_ready sampled high in DONE at edge t: out_valid=0 from t+1. A new start is accepted at edge t+1 or later.
- out_ready while out_valid=0 has no effect.
- in_valid gaps stall the counters; no element is lost or duplicated.

## Test plan

- Reset, then a 3x3 load with start, size=01 and elements 1..9 streamed back-to-back:
  - out_valid rises 10 cycles after the start edge;
  - matrix_out[199:176]=01_02_03, [159:136]=04_05_06, [119:96]=07_08_09;
  - every other bit is 0.
- 5x5 load with elements 0x01..0x19:
  - [199:192]=0x01, [7:0]=0x19, [159:152]=0x06;
  - in_ready=0 after the 25th accept.
- 2x2 load with elements A1,A2,A3,A4 and in_valid toggled every other cycle:
  - [199:184]=A1A2, [159:144]=A3A4, all else 0;
  - out_valid appears 8 cycles after start.
- Back-to-back sizes: a 5x5 load of all 0xFF, then out_ready, then a 2x2 load of all 0x11:
  - the second result holds only the four 0x11 bytes; all other bits are 0, confirming the buffer is cleared.
- Restart and reset handling:
  - start (size=10) after 7 accepts of a 3x3 load restarts the load; a 4x4 load of 16 elements then completes correctly.
  - reset asserted in DONE makes out_valid=0, busy=0 and matrix_out=0 next cycle.
- Stray inputs:
  - in_valid in IDLE and start in DONE have no effect;
  - out_valid is held until out_ready arrives, then drops in exactly 1 cycle.
